// File: rtl/fpu_ss_pkg.sv
// fpu_ss_pkg: shared types for the FPU subsystem input buffer.
package fpu_ss_pkg;
  localparam int X_ID_WIDTH = 4;
  typedef struct packed {
    logic [31:0]           instr;
    logic [2:0][31:0]      rs;
    logic [2:0]            rs_valid;
    logic [X_ID_WIDTH-1:0] id;
    logic [1:0]            mode;
  } in_buf_entry_t;
endpackage

// File: rtl/fpu_ss_input_buffer.sv
// fpu_ss_input_buffer: commit-aware instruction FIFO that drops killed entries at the head.
// FPU_SS_IN_BUF_BYPASS_EN enables a same-cycle pass-through when the buffer is empty.
module fpu_ss_input_buffer
  import fpu_ss_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  in_buf_entry_t            push_data_i,
  output logic                     pop_valid_o,
  input  logic                     pop_ready_i,
  output in_buf_entry_t            pop_data_o,
  input  logic                     commit_valid_i,
  input  logic [ID_WIDTH-1:0]      commit_id_i,
  input  logic                     commit_kill_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  in_buf_entry_t    mem_q [DEPTH];
  logic [DEPTH-1:0] killed_q, kill_match;
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]    head, tail;
  logic kill, push_kill, full, empty, head_dead, pop_valid_buf, do_push, do_rd, byp;
  assign kill = commit_valid_i & commit_kill_i;
  for (genvar g = 0; g < DEPTH; g++) begin : g_kill
    assign kill_match[g] = kill & (mem_q[g].id == commit_id_i);
  end
  assign head          = rd_ptr_q[AW-1:0];
  assign tail          = wr_ptr_q[AW-1:0];
  assign full          = (head == tail) & (rd_ptr_q[AW] != wr_ptr_q[AW]);
  assign empty         = rd_ptr_q == wr_ptr_q;
  assign push_kill     = kill & (push_data_i.id == commit_id_i);
  assign head_dead     = killed_q[head] | kill_match[head];
  assign pop_valid_buf = ~empty & ~head_dead;
  assign push_ready_o  = ~full;
  assign count_o       = wr_ptr_q - rd_ptr_q;
  assign empty_o       = empty;
  assign do_rd         = ~empty & (head_dead | pop_ready_i);
`ifdef FPU_SS_IN_BUF_BYPASS_EN
  assign byp         = empty & push_valid_i & ~push_kill;
  assign pop_valid_o = pop_valid_buf | byp;
  assign pop_data_o  = byp ? push_data_i : mem_q[head];
  assign do_push     = push_valid_i & ~full & ~(byp & pop_ready_i);
`else
  assign byp         = 1'b0;
  assign pop_valid_o = pop_valid_buf | byp;
  assign pop_data_o  = mem_q[head];
  assign do_push     = push_valid_i & ~full;
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      killed_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // stale slots may pick up a kill flag; it is overwritten on the next push there
      killed_q <= killed_q | kill_match;
      if (do_push) begin
        mem_q[tail]    <= push_data_i;
        killed_q[tail] <= push_kill;
        wr_ptr_q       <= wr_ptr_q + 1'b1;
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_fpu_ss_input_buffer.sv
// tb_fpu_ss_input_buffer: directed vectors for the commit-aware input buffer.
module tb_fpu_ss_input_buffer;
  import fpu_ss_pkg::*;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_valid = 1'b0, pop_ready = 1'b0;
  logic          commit_valid = 1'b0, commit_kill = 1'b0;
  logic [3:0]    commit_id = '0;
  in_buf_entry_t push_data = '0, pop_data;
  logic          push_ready, pop_valid, empty;
  logic [2:0]    count;
  int vectors = 0, errs = 0;
  fpu_ss_input_buffer #(.DEPTH(4), .ID_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .push_valid_i(push_valid), .push_ready_o(push_ready), .push_data_i(push_data),
    .pop_valid_o(pop_valid), .pop_ready_i(pop_ready), .pop_data_o(pop_data),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .count_o(count), .empty_o(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_push(input logic v, input int tag);
    push_valid      = v;
    push_data       = '0;
    push_data.instr = 32'hA000_0000 | tag;
    push_data.id    = tag[3:0];
    push_data.rs[1] = 32'h1111_0000 | tag;
  endtask
  task automatic set_kill(input logic v, input logic [3:0] id);
    commit_valid = v;
    commit_kill  = v;
    commit_id    = id;
  endtask
  task automatic pop_expect(input string tag, input int exp_tag);
    #1;
    chk({tag, "_valid"}, 32'(pop_valid), 1);
    chk({tag, "_instr"}, pop_data.instr, 32'hA000_0000 | exp_tag);
  endtask
  initial begin
    #1;
    chk("rst_ready", 32'(push_ready), 1);
    chk("rst_pvalid", 32'(pop_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_data", pop_data.instr, 0);
    #12 rst = 1'b0;
    @(negedge clk);
    tick();
    // fill 1..4
    for (int i = 1; i <= 4; i++) begin
      set_push(1, i);
      tick();
      if (i == 1) begin
        set_push(0, 0);
        pop_expect("lat", 1);
        set_push(1, 2);
        i++;
        tick();
      end
    end
    set_push(0, 0);
    #1;
    chk("full_ready", 32'(push_ready), 0);
    chk("full_count", 32'(count), 4);
    // push while full with pop: the push must not be accepted
    set_push(1, 15);
    pop_ready = 1'b1;
    pop_expect("fullpop", 1);
    tick();
    set_push(0, 0);
    #1 chk("fullpop_count", 32'(count), 3);
    for (int i = 2; i <= 4; i++) begin
      pop_expect("drain", i);
      tick();
    end
    #1;
    chk("drain_empty", 32'(empty), 1);
    chk("drain_pvalid", 32'(pop_valid), 0);
    chk("drain_count", 32'(count), 0);
    // streaming wrap-around of 10 entries
    pop_ready = 1'b0;
    set_push(1, 16);
    tick();
    pop_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      set_push(1, 16 + k);
      pop_expect("stream", 16 + k - 1);
      chk("stream_count", 32'(count), 1);
      tick();
    end
    set_push(0, 0);
    pop_expect("stream_last", 25);
    tick();
    #1 chk("stream_empty", 32'(empty), 1);
    // head kill
    pop_ready = 1'b0;
    set_push(1, 5);
    tick();
    set_push(1, 6);
    tick();
    set_push(0, 0);
    set_kill(1, 4'd5);
    #1;
    chk("hk_pvalid", 32'(pop_valid), 0);
    chk("hk_count2", 32'(count), 2);
    tick();
    set_kill(0, 0);
    pop_expect("hk_head", 6);
    chk("hk_count1", 32'(count), 1);
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    #1 chk("hk_empty", 32'(empty), 1);
    // mid kill
    for (int i = 1; i <= 3; i++) begin
      set_push(1, i);
      tick();
    end
    set_push(0, 0);
    set_kill(1, 4'd2);
    tick();
    set_kill(0, 0);
    pop_ready = 1'b1;
    pop_expect("mk_first", 1);
    tick();
    #1;
    chk("mk_drop_pvalid", 32'(pop_valid), 0);
    chk("mk_drop_count", 32'(count), 2);
    tick();
    pop_expect("mk_third", 3);
    tick();
    #1 chk("mk_count", 32'(count), 0);
    pop_ready = 1'b0;
    // kill on the push cycle
    set_push(1, 7);
    set_kill(1, 4'd7);
    tick();
    set_push(0, 0);
    set_kill(0, 0);
    #1;
    chk("kp_pvalid", 32'(pop_valid), 0);
    chk("kp_count1", 32'(count), 1);
    tick();
    #1;
    chk("kp_pvalid2", 32'(pop_valid), 0);
    chk("kp_count0", 32'(count), 0);
    // asynchronous reset mid-operation
    for (int i = 1; i <= 3; i++) begin
      set_push(1, 8 + i);
      tick();
    end
    set_push(0, 0);
    #1 chk("mr_count3", 32'(count), 3);
    #2 rst = 1'b1;
    #1;
    chk("mr_count", 32'(count), 0);
    chk("mr_pvalid", 32'(pop_valid), 0);
    chk("mr_ready", 32'(push_ready), 1);
    chk("mr_empty", 32'(empty), 1);
    chk("mr_data", pop_data.instr, 0);
    @(negedge clk) rst = 1'b0;
    tick();
`ifdef FPU_SS_IN_BUF_BYPASS_EN
    set_push(1, 9);
    pop_ready = 1'b1;
    pop_expect("byp", 9);
    chk("byp_count", 32'(count), 0);
    tick();
    set_push(0, 0);
    pop_ready = 1'b0;
    #1;
    chk("byp_count_after", 32'(count), 0);
    chk("byp_empty", 32'(empty), 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/fpu_ss_input_buffer.md
Name: fpu_ss_input_buffer

Overview:
- Upstream neighbour of the FPU subsystem controller: a commit-aware instruction FIFO between the CV-X-IF issue handshake and the controller's in_buf pop port.
- Holds accepted offloaded instructions with their operands and ID until the controller dispatches them.
- Tracks commit_kill per entry and silently discards killed instructions at the head, so the controller never sees them.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- ID_WIDTH, 4, instruction ID width; equals fpu_ss_pkg::X_ID_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- push_valid_i  in  1  issue side has an accepted instruction.
- push_ready_o  out  1  buffer can accept.
- push_data_i  in  in_buf_entry_t  instruction word, rs[0..2] operands, rs_valid[2:0], id, mode.
- pop_valid_o  out  1  live (non-killed) head entry available.
- pop_ready_i  in  1  controller consumes head.
- pop_data_o  out  in_buf_entry_t  head entry.
- commit_valid_i  in  1  commit strobe.
- commit_id_i  in  ID_WIDTH  committed/killed ID.
- commit_kill_i  in  1  kill the instruction with commit_id_i.
- count_o  out  $clog2(DEPTH)+1  occupied entries, including killed ones.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage: DEPTH-entry circular array. Pointers wr_ptr_q and rd_ptr_q are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - full = (index bits equal) & (wrap bits differ).
  - empty = pointers equal.
- Per-entry killed_q flag is stored alongside the payload.
- Reset (asynchronous, while rst_i=1): pointers=0, all killed_q=0, payload cleared to '0.
  - Outputs during and after reset: push_ready_o=1, pop_valid_o=0, pop_data_o='0, count_o=0, empty_o=1.
- Push: when push_valid_i & push_ready_o, write at wr_ptr and increment wr_ptr (wraps naturally).
- push_ready_o = ~full. A pop in the same cycle does not free space for the push.
- The killed flag of a newly written entry is set if commit_valid_i & commit_kill_i & commit_id_i==push_data_i.id in the push cycle.
- Kill: on commit_valid_i & commit_kill_i, every stored entry with id==commit_id_i gets killed_q=1. A commit without kill has no effect on storage.
- Head handling:
  - pop_valid_o = ~empty & ~killed_q[head] & ~kill_hit_head.
  - kill_hit_head is a same-cycle kill matching the head ID; a kill takes effect combinationally on the pop side.
  - pop_data_o = entry[head], driven regardless of pop_valid_o.
  - Live head with pop_valid_o & pop_ready_i: rd_ptr increments.
  - Killed head (registered flag or same-cycle kill): rd_ptr increments automatically, independent of pop_ready_i. At most one entry is dropped per cycle. A dropped entry never produces pop_valid_o.
- Latency: a pushed entry into an empty buffer is visible on pop_valid_o the next cycle.
- Simultaneous push and pop (or push and drop) when neither full nor empty: both proceed and count_o is unchanged.
- count_o = wr_ptr_q - rd_ptr_q (modular, full pointer width).
- A kill of an ID not present is ignored. A kill matching several entries kills all of them; the issue side guarantees unique IDs in flight.
- Reset mid-operation: all contents discarded immediately and asynchronously. No partial pop is visible.

Optional Feature:
- Macro FPU_SS_IN_BUF_BYPASS_EN.
- When defined: if the buffer is empty and push_valid_i=1 with no same-cycle kill of that ID:
  - pop_valid_o=1 and pop_data_o=push_data_i combinationally.
  - If pop_ready_i=1, the entry is consumed without being written; pointers and count are unchanged.
  - Otherwise the entry is written normally.
- When undefined: one-cycle latency as in Behaviour.

Decomposition:
- fpu_ss_pkg holds in_buf_entry_t (instr[31:0], rs[2:0][31:0], rs_valid[2:0], id[X_ID_WIDTH-1:0], mode[1:0]) and X_ID_WIDTH.
- No sub-module. The kill-match compare is a generate loop inside the block.

Test Plan:
- Fill/drain: DEPTH=4, push IDs 1,2,3,4 back-to-back -> push_ready_o=0 after the 4th push and count_o=4. Pop 4 times -> IDs 1,2,3,4 in order, empty_o=1.
- Wrap-around: push/pop 10 entries in a streaming pattern -> pointer wrap, order preserved, count_o never >4.
- Head kill: buffer holds IDs 5,6; commit_kill for ID 5 with pop_ready_i=0 -> pop_valid_o=0 that cycle, next cycle the head is ID 6 with pop_valid_o=1, count_o goes 2->1.
- Mid kill: holds 1,2,3; kill ID 2, then pop twice -> controller sees IDs 1,3 only; count_o reaches 0 after 3 cycles.
- Kill on push cycle: push ID 7 while commit_kill ID 7 -> entry stored killed, dropped next cycle, pop_valid_o never asserted.
- Reset mid-operation: 3 entries held, assert rst_i asynchronously -> count_o=0, pop_valid_o=0, push_ready_o=1 before the next clock edge.
- With FPU_SS_IN_BUF_BYPASS_EN: empty buffer, push ID 9 with pop_ready_i=1 -> pop_valid_o=1 same cycle, count_o remains 0.
